// File: rtl/mem_access.sv
// mem_access: MIPS MEM stage. Drives a request/ready data-RAM bus, places store lanes, aligns/extends loads.
// Optional watchdog: define MEM_ACCESS_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES and pulse bus_error.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag_in,
    input  logic        mem_write_flag_in,
    input  logic        mem_sign_ext_flag_in,
    input  logic [3:0]  mem_sel_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [31:0] result_in,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_reg_addr_in,
    input  logic [31:0] debug_pc_addr_in,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready,
    output logic        stall_request,
    output logic        mem_load_flag,
    output logic [31:0] result_out,
    output logic        write_reg_en_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        bus_error,
    output logic [31:0] debug_pc_addr_out
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic        access;
    logic        is_load;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
    logic       bus_err_q;
`endif

    function automatic logic [31:0] place_store(input logic [31:0] d, input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: place_store = {4{d[7:0]}};
            4'b0011, 4'b1100:                   place_store = {2{d[15:0]}};
            default:                            place_store = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [3:0] sel,
                                                 input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        case (sel)
            4'b0001: b = w[7:0];
            4'b0010: b = w[15:8];
            4'b0100: b = w[23:16];
            4'b1000: b = w[31:24];
            default: b = 8'h00;
        endcase
        h = sel[3] ? w[31:16] : w[15:0];
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: extract_load = {{24{sext & b[7]}}, b};
            4'b0011, 4'b1100:                   extract_load = {{16{sext & h[15]}}, h};
            4'b1111:                            extract_load = w;
            default:                            extract_load = 32'h0000_0000;
        endcase
    endfunction

    assign access  = (mem_read_flag_in | mem_write_flag_in) & (mem_sel_in != 4'b0000);
    assign is_load = mem_read_flag_in & ~mem_write_flag_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ram_en         <= 1'b0;
            ram_write_en   <= 4'b0000;
            ram_addr       <= 32'h0000_0000;
            ram_write_data <= 32'h0000_0000;
            rdata_q        <= 32'h0000_0000;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wd_cnt         <= 8'd0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        ram_addr       <= {result_in[31:2], 2'b00};
                        ram_write_en   <= mem_write_flag_in ? mem_sel_in : 4'b0000;
                        ram_write_data <= place_store(mem_write_data_in, mem_sel_in);
                        ram_en         <= 1'b1;
                        state          <= WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wd_cnt         <= 8'd0;
`endif
                    end
                end
                WAIT: begin
                    // Bus outputs stay frozen until the slave answers (or the watchdog fires).
                    if (ram_ready) begin
                        rdata_q      <= ram_read_data;
                        ram_en       <= 1'b0;
                        ram_write_en <= 4'b0000;
                        state        <= DONE;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wd_cnt == TO_LAST) begin
                        rdata_q      <= 32'h0000_0000;
                        ram_en       <= 1'b0;
                        ram_write_en <= 4'b0000;
                        bus_err_q    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign bus_error = bus_err_q;
`else
    assign bus_error = 1'b0;
`endif

    // Stall drops in DONE so the pipeline advances in the same cycle the load data is presented.
    assign stall_request      = rst & access & (state != DONE);
    assign mem_load_flag      = rst & mem_read_flag_in;
    assign result_out         = !rst ? 32'h0000_0000 :
                                (state == DONE && is_load) ?
                                extract_load(rdata_q, mem_sel_in, mem_sign_ext_flag_in) : result_in;
    assign write_reg_en_out   = rst & write_reg_en_in & ~mem_write_flag_in & ~stall_request & ~bus_error;
    assign write_reg_addr_out = rst ? write_reg_addr_in : 5'd0;
    assign debug_pc_addr_out  = debug_pc_addr_in;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed transactions, a spec-level expectation model and a per-cycle compare process.
module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in, result_in, debug_pc_addr_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        ram_ready;
    logic        stall_request, mem_load_flag;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        bus_error;
    logic [31:0] debug_pc_addr_out;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
        .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
        .mem_write_data_in(mem_write_data_in), .result_in(result_in),
        .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
        .debug_pc_addr_in(debug_pc_addr_in),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ready(ram_ready),
        .stall_request(stall_request), .mem_load_flag(mem_load_flag),
        .result_out(result_out), .write_reg_en_out(write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out), .bus_error(bus_error),
        .debug_pc_addr_out(debug_pc_addr_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0, bus_chk = 1'b0, we_chk = 1'b0, wd_chk = 1'b0;
    logic        exp_ram_en, exp_stall, exp_wren, exp_load, exp_berr;
    logic [31:0] exp_result, exp_addr, exp_wdata, exp_dbg;
    logic [3:0]  exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] last_addr, last_wdata, last_result;
    logic [3:0]  last_we;
    logic        last_wren, last_berr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lane placement of store data from the spec: replicate the low byte/half over the word.
    function automatic logic [31:0] m_store(input logic [31:0] d, input logic [3:0] sel);
        if ($countones(sel) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sel == 4'b0011 || sel == 4'b1100) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Load extraction: shift the selected lane down, mask, then optionally sign-extend.
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [3:0] sel, input logic sx);
        int          lane;
        int          bits;
        logic [31:0] v;
        lane = 0;
        bits = 8;
        if (sel == 4'b1111) return w;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) lane = i;
        end else if (sel == 4'b0011 || sel == 4'b1100) begin
            bits = 16;
            lane = (sel == 4'b0011) ? 0 : 2;
        end else begin
            return 32'h0;
        end
        v = (w >> (8 * lane)) & ((32'h1 << bits) - 32'h1);
        if (sx && v[bits - 1]) v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ram_en", 32'(ram_en), 32'(exp_ram_en));
            check("stall_request", 32'(stall_request), 32'(exp_stall));
            check("result_out", result_out, exp_result);
            check("write_reg_en_out", 32'(write_reg_en_out), 32'(exp_wren));
            check("write_reg_addr_out", 32'(write_reg_addr_out), 32'(exp_waddr));
            check("mem_load_flag", 32'(mem_load_flag), 32'(exp_load));
            check("bus_error", 32'(bus_error), 32'(exp_berr));
            check("debug_pc", debug_pc_addr_out, exp_dbg);
            if (bus_chk) check("ram_addr", ram_addr, exp_addr);
            if (we_chk)  check("ram_write_en", 32'(ram_write_en), 32'(exp_we));
            if (wd_chk)  check("ram_write_data", ram_write_data, exp_wdata);
        end
    end

    task automatic set_nop(input logic [31:0] res, input logic wen, input logic [4:0] wa,
                           input logic [31:0] pc);
        mem_read_flag_in = 1'b0; mem_write_flag_in = 1'b0; mem_sign_ext_flag_in = 1'b0;
        mem_sel_in = 4'b0000; mem_write_data_in = 32'h0; result_in = res;
        write_reg_en_in = wen; write_reg_addr_in = wa; debug_pc_addr_in = pc;
        ram_ready = 1'b0; ram_read_data = 32'h0;
        exp_ram_en = 1'b0; bus_chk = 1'b0; we_chk = 1'b0; wd_chk = 1'b0;
        exp_stall = 1'b0; exp_result = res; exp_wren = wen; exp_waddr = wa;
        exp_load = 1'b0; exp_berr = 1'b0; exp_dbg = pc;
    endtask

    task automatic do_alu(input logic [31:0] res, input logic wen, input logic [4:0] wa,
                          input logic [31:0] pc);
        set_nop(res, wen, wa, pc);
        @(posedge clk); #1;
    endtask

    // One load/store from the IDLE cycle to the end of DONE. wait_n < 0 means ram_ready never comes.
    task automatic do_access(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                             input int wait_n, input logic wen, input logic [4:0] wa,
                             input logic [31:0] pc, output int stalls);
        bit to;
        int n;
        to = (wait_n < 0);
        n  = to ? TO : wait_n + 1;
        stalls = 0;
        mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sign_ext_flag_in = sx; mem_sel_in = sel;
        mem_write_data_in = wdata; result_in = addr; write_reg_en_in = wen;
        write_reg_addr_in = wa; debug_pc_addr_in = pc;
        ram_ready = 1'b1; ram_read_data = ~rdata;
        exp_ram_en = 1'b0; bus_chk = 1'b0; we_chk = 1'b0; wd_chk = 1'b0;
        exp_stall = 1'b1; exp_result = addr; exp_wren = 1'b0; exp_waddr = wa;
        exp_load = rd; exp_berr = 1'b0; exp_dbg = pc;
        @(negedge clk); if (stall_request) stalls++;
        @(posedge clk); #1;
        exp_ram_en = 1'b1; bus_chk = 1'b1; we_chk = 1'b1; wd_chk = wr;
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_we = wr ? sel : 4'b0000;
        exp_wdata = m_store(wdata, sel);
        for (int k = 0; k < n; k++) begin
            ram_ready = (!to && k == wait_n);
            ram_read_data = ram_ready ? rdata : ~rdata;
            @(negedge clk); if (stall_request) stalls++;
            last_addr = ram_addr; last_we = ram_write_en; last_wdata = ram_write_data;
            @(posedge clk); #1;
        end
        ram_ready = 1'b0; ram_read_data = ~rdata;
        exp_ram_en = 1'b0; exp_stall = 1'b0; exp_berr = to;
        bus_chk = 1'b0; wd_chk = 1'b0; we_chk = !to; exp_we = 4'b0000;
        exp_result = (rd && !wr) ? (to ? 32'h0 : m_load(rdata, sel, sx)) : addr;
        exp_wren = wen && !wr && !to;
        @(negedge clk); if (stall_request) stalls++;
        last_result = result_out; last_wren = write_reg_en_out; last_berr = bus_error;
        @(posedge clk); #1;
        set_nop(32'h0, 1'b0, 5'd0, pc + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        int st;
        mem_read_flag_in = 1'b1; mem_write_flag_in = 1'b0; mem_sign_ext_flag_in = 1'b0;
        mem_sel_in = 4'b1111; mem_write_data_in = 32'h0; result_in = 32'h1234;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd7; debug_pc_addr_in = 32'hBFC0_0000;
        ram_ready = 1'b1; ram_read_data = 32'h0;
        #1 rst = 1'b0;
        #11;
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_write_en", 32'(ram_write_en), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_write_data", ram_write_data, 32'd0);
        check("rst_stall", 32'(stall_request), 32'd0);
        check("rst_load_flag", 32'(mem_load_flag), 32'd0);
        check("rst_result_out", result_out, 32'd0);
        check("rst_wren", 32'(write_reg_en_out), 32'd0);
        check("rst_waddr", 32'(write_reg_addr_out), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_debug_pc", debug_pc_addr_out, 32'hBFC0_0000);
        @(posedge clk); #1;
        check("rst_hold_ram_en", 32'(ram_en), 32'd0);
        set_nop(32'h0, 1'b0, 5'd0, 32'hBFC0_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        do_alu(32'h0000_1234, 1'b1, 5'd3, 32'h0040_0000);
        do_alu(32'hFFFF_0001, 1'b1, 5'd4, 32'h0040_0004);

        // LW, zero wait
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h1003, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 5'd8,
                  32'h0040_0008, st);
        check("lw_ram_addr", last_addr, 32'h0000_1000);
        check("lw_stall_cycles", 32'(st), 32'd2);
        check("lw_result", last_result, 32'hDEAD_BEEF);
        check("lw_wren", 32'(last_wren), 32'd1);

        // LB signed / unsigned, back-to-back
        do_access(1'b1, 1'b0, 1'b1, 4'b0100, 32'h2002, 32'h0, 32'h0080_0000, 0, 1'b1, 5'd9,
                  32'h0040_000C, st);
        check("lb_signed", last_result, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 1'b0, 4'b0100, 32'h2002, 32'h0, 32'h0080_0000, 0, 1'b1, 5'd9,
                  32'h0040_0010, st);
        check("lb_unsigned", last_result, 32'h0000_0080);

        // SH
        do_access(1'b0, 1'b1, 1'b0, 4'b1100, 32'h3002, 32'h0000_ABCD, 32'h0, 0, 1'b1, 5'd10,
                  32'h0040_0014, st);
        check("sh_write_data", last_wdata, 32'hABCD_ABCD);
        check("sh_write_en", 32'(last_we), 32'b1100);
        check("sh_wren", 32'(last_wren), 32'd0);

        // SB lane 1, LH sign-extended low half, illegal select pattern
        do_access(1'b0, 1'b1, 1'b0, 4'b0010, 32'h3101, 32'h1234_5678, 32'h0, 1, 1'b0, 5'd0,
                  32'h0040_0018, st);
        check("sb_write_data", last_wdata, 32'h7878_7878);
        do_access(1'b1, 1'b0, 1'b1, 4'b0011, 32'h3200, 32'h0, 32'h1234_8765, 0, 1'b1, 5'd14,
                  32'h0040_001C, st);
        check("lh_signed", last_result, 32'hFFFF_8765);
        do_access(1'b1, 1'b0, 1'b0, 4'b0101, 32'h3300, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 5'd15,
                  32'h0040_0020, st);

        // Wait states: ready on the 4th WAIT cycle
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h4008, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 5'd16,
                  32'h0040_0024, st);
        check("wait_stall_cycles", 32'(st), 32'd5);
        check("wait_result", last_result, 32'h0BAD_F00D);

        // Both flags: treated as a store, no writeback
        do_access(1'b1, 1'b1, 1'b0, 4'b0011, 32'h5000, 32'h5555_AAAA, 32'h0, 0, 1'b1, 5'd17,
                  32'h0040_0028, st);
        check("rw_write_data", last_wdata, 32'hAAAA_AAAA);

        // Read flag with no lanes selected is not an access
        set_nop(32'h0000_7777, 1'b1, 5'd18, 32'h0040_002C);
        mem_read_flag_in = 1'b1; exp_load = 1'b1;
        @(posedge clk); #1;
        do_alu(32'h0000_8888, 1'b0, 5'd19, 32'h0040_0030);

        // Reset asserted in WAIT
        chk_en = 1'b0;
        mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h4000;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd11; ram_ready = 1'b0;
        @(posedge clk); #1;
        check("rstwait_pre_ram_en", 32'(ram_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstwait_ram_en", 32'(ram_en), 32'd0);
        check("rstwait_stall", 32'(stall_request), 32'd0);
        check("rstwait_result", result_out, 32'd0);
        check("rstwait_wren", 32'(write_reg_en_out), 32'd0);
        check("rstwait_load_flag", 32'(mem_load_flag), 32'd0);
        @(posedge clk); #1;
        check("rstwait_hold_ram_en", 32'(ram_en), 32'd0);
        set_nop(32'h0000_0050, 1'b1, 5'd12, 32'h0040_0034);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h4004, 32'h0, 32'hCAFE_0001, 0, 1'b1, 5'd20,
                  32'h0040_0038, st);
        check("after_rst_stall_cycles", 32'(st), 32'd2);
        check("after_rst_result", last_result, 32'hCAFE_0001);

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h6000, 32'h0, 32'h1111_2222, -1, 1'b1, 5'd13,
                  32'h0040_003C, st);
        check("to_stall_cycles", 32'(st), 32'(1 + TO));
        check("to_bus_error", 32'(last_berr), 32'd1);
        check("to_result", last_result, 32'd0);
        check("to_wren", 32'(last_wren), 32'd0);
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h6004, 32'h0, 32'h3333_4444, 0, 1'b1, 5'd21,
                  32'h0040_0040, st);
        check("after_to_result", last_result, 32'h3333_4444);
`endif

        do_alu(32'h0000_9999, 1'b1, 5'd22, 32'h0040_0044);
        do_alu(32'h0000_AAAA, 1'b0, 5'd23, 32'h0040_0048);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
